ex_operand_stage: RTL and testbench

ID/EX pipeline register and operand-select stage that sits directly upstream of the 32-bit `alu`. It captures decoded operands and control from ID, translates ALU class plus funct into the 4-bit `alu` op code, and resolves operand hazards by forwarding from EX/MEM and MEM/WB. It also drives `din_A`, `din_B` and `op` of the ALU. It supports pipeline stall (hold) and flush (bubble insertion).

---
 rtl/cpu_pkg.sv | 63 ++++++
 rtl/fwd_mux.sv | 38 +++
 rtl/ex_operand_stage.sv | 130 +++++++++++++
 tb/tb_ex_operand_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared ALU op codes, ALU class / funct encodings and decode.
//  Revision    : 1.0
// ============================================================================
package cpu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    typedef enum logic [1:0] {
        CLS_ADD   = 2'b00,
        CLS_SUB   = 2'b01,
        CLS_RTYPE = 2'b10,
        CLS_OR    = 2'b11
    } alu_class_e;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;

    typedef struct packed {
        logic [3:0] op;
        logic       illegal;
    } op_dec_t;

    // Unsupported R-type functs fall back to ADD and raise the illegal flag.
    function automatic op_dec_t decode_op(input logic [1:0] cls, input logic [5:0] funct);
        op_dec_t d;
        d.op      = ALU_ADD;
        d.illegal = 1'b0;
        case (cls)
            CLS_ADD: d.op = ALU_ADD;
            CLS_SUB: d.op = ALU_SUB;
            CLS_OR:  d.op = ALU_OR;
            default: begin
                case (funct)
                    FN_ADD:  d.op = ALU_ADD;
                    FN_SUB:  d.op = ALU_SUB;
                    FN_AND:  d.op = ALU_AND;
                    FN_OR:   d.op = ALU_OR;
                    FN_XOR:  d.op = ALU_XOR;
                    FN_NOR:  d.op = ALU_NOR;
                    FN_ADDU, FN_SUBU: d.illegal = 1'b1;
                    default: d.illegal = 1'b1;
                endcase
            end
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_mux
//  Description : Three-way operand forwarding select (EX/MEM > MEM/WB > RF).
//  Revision    : 1.0
// ============================================================================
module fwd_mux #(
    parameter int W  = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] idx_i,
    input  logic [W-1:0]  rf_data_i,
    input  logic          exmem_reg_write_i,
    input  logic [RW-1:0] exmem_rd_i,
    input  logic [W-1:0]  exmem_data_i,
    input  logic          memwb_reg_write_i,
    input  logic [RW-1:0] memwb_rd_i,
    input  logic [W-1:0]  memwb_data_i,
    output logic [W-1:0]  data_o
);

    logic exmem_hit;
    logic memwb_hit;

    assign exmem_hit = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == idx_i);
    assign memwb_hit = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == idx_i);

    always_comb begin
        data_o = rf_data_i;
        if (exmem_hit) begin
            data_o = exmem_data_i;
        end else if (memwb_hit) begin
            data_o = memwb_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_operand_stage
//  Description : ID/EX register with ALU op decode and operand forwarding.
//  Revision    : 1.0
// ============================================================================
module ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int W  = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [W-1:0]  id_rs_data,
    input  logic [W-1:0]  id_rt_data,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [15:0]   id_imm,
    input  logic          id_imm_zext,
    input  logic          id_alu_src,
    input  logic [1:0]    id_alu_class,
    input  logic [5:0]    id_funct,
    input  logic          id_reg_write,
    input  logic          exmem_reg_write,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [RW-1:0] memwb_rd,
    input  logic [W-1:0]  exmem_data,
    input  logic [W-1:0]  memwb_data,
    output logic [W-1:0]  din_A,
    output logic [W-1:0]  din_B,
    output logic [3:0]    op,
    output logic          ex_valid,
    output logic [RW-1:0] ex_rd,
    output logic          ex_reg_write,
    output logic          ex_illegal
);

    typedef struct packed {
        logic          valid;
        logic          reg_write;
        logic          illegal;
        logic          alu_src;
        logic [3:0]    op;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [W-1:0]  rs_data;
        logic [W-1:0]  rt_data;
        logic [W-1:0]  imm_ext;
    } ex_reg_t;

    ex_reg_t ex_q;
    ex_reg_t ex_d;
    op_dec_t dec;
    logic [W-1:0] imm_ext;
    logic [W-1:0] fwd_rs;
    logic [W-1:0] fwd_rt;

    assign dec     = decode_op(id_alu_class, id_funct);
    assign imm_ext = id_imm_zext ? {{(W-16){1'b0}}, id_imm}
                                 : {{(W-16){id_imm[15]}}, id_imm};

    // Flush beats stall; an all-zero record is the bubble.
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (!stall) begin
            ex_d.valid     = id_valid;
            ex_d.reg_write = id_reg_write;
            ex_d.illegal   = dec.illegal;
            ex_d.alu_src   = id_alu_src;
            ex_d.op        = dec.op;
            ex_d.rs        = id_rs;
            ex_d.rt        = id_rt;
            ex_d.rd        = id_rd;
            ex_d.rs_data   = id_rs_data;
            ex_d.rt_data   = id_rt_data;
            ex_d.imm_ext   = imm_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    fwd_mux #(.W(W), .RW(RW)) u_fwd_rs (
        .idx_i             (ex_q.rs),
        .rf_data_i         (ex_q.rs_data),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_rd_i        (exmem_rd),
        .exmem_data_i      (exmem_data),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_rd_i        (memwb_rd),
        .memwb_data_i      (memwb_data),
        .data_o            (fwd_rs)
    );

    fwd_mux #(.W(W), .RW(RW)) u_fwd_rt (
        .idx_i             (ex_q.rt),
        .rf_data_i         (ex_q.rt_data),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_rd_i        (exmem_rd),
        .exmem_data_i      (exmem_data),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_rd_i        (memwb_rd),
        .memwb_data_i      (memwb_data),
        .data_o            (fwd_rt)
    );

    assign din_A        = fwd_rs;
    assign din_B        = ex_q.alu_src ? ex_q.imm_ext : fwd_rt;
    assign op           = ex_q.op;
    assign ex_valid     = ex_q.valid;
    assign ex_rd        = ex_q.rd;
    assign ex_reg_write = ex_q.reg_write & ex_q.valid;
    assign ex_illegal   = ex_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_operand_stage
//  Description : Scoreboard bench for ex_operand_stage with directed vectors.
//  Revision    : 1.0
// ============================================================================
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_imm;
    logic        id_imm_zext, id_alu_src;
    logic [1:0]  id_alu_class;
    logic [5:0]  id_funct;
    logic        id_reg_write;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_data, memwb_data;
    logic [31:0] din_A, din_B;
    logic [3:0]  op;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_illegal;

    always #5 clk = ~clk;

    ex_operand_stage #(.W(32), .RW(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
        .id_imm_zext(id_imm_zext), .id_alu_src(id_alu_src),
        .id_alu_class(id_alu_class), .id_funct(id_funct),
        .id_reg_write(id_reg_write),
        .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_data(exmem_data), .memwb_data(memwb_data),
        .din_A(din_A), .din_B(din_B), .op(op), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        v;
        logic        rw;
        logic        ill;
        logic [4:0]  rd;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s.%s: got 0x%08h expected 0x%08h", nm, fld, act, req);
    endtask

    // Monitor: compares every queued expectation at the next sample point.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                cmp(e.name, "din_A", din_A, e.a);
                cmp(e.name, "din_B", din_B, e.b);
                cmp(e.name, "op", {28'h0, op}, {28'h0, e.op});
                cmp(e.name, "ex_valid", {31'h0, ex_valid}, {31'h0, e.v});
                cmp(e.name, "ex_reg_write", {31'h0, ex_reg_write}, {31'h0, e.rw});
                cmp(e.name, "ex_illegal", {31'h0, ex_illegal}, {31'h0, e.ill});
                cmp(e.name, "ex_rd", {27'h0, ex_rd}, {27'h0, e.rd});
            end
        end
    end

    task automatic push(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] o, input logic v, input logic rw,
                        input logic ill, input logic [4:0] rd);
        exp_t e;
        e.name = nm; e.a = a; e.b = b; e.op = o; e.v = v; e.rw = rw; e.ill = ill; e.rd = rd;
        q.push_back(e);
    endtask

    task automatic expect_at_negedge(input string nm, input logic [31:0] a, input logic [31:0] b,
                                     input logic [3:0] o, input logic v, input logic rw,
                                     input logic ill, input logic [4:0] rd);
        push(nm, a, b, o, v, rw, ill, rd);
        @(negedge clk);
        #1;
    endtask

    task automatic expect_now(input string nm, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] o, input logic v, input logic rw,
                              input logic ill, input logic [4:0] rd);
        push(nm, a, b, o, v, rw, ill, rd);
        -> chk_ev;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [15:0] imm, input logic zext, input logic src,
                          input logic [1:0] cls, input logic [5:0] fn, input logic rw);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_imm_zext = zext;
        id_alu_src = src; id_alu_class = cls; id_funct = fn; id_reg_write = rw;
    endtask

    task automatic clear_fwd();
        exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_data = 32'h0;
        memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_data = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [1:0] t_cls [7] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [5:0] t_fn  [7] = '{6'h00, 6'h00, 6'h20, 6'h22, 6'h24, 6'h25, 6'h26};
    logic [3:0] t_op  [7] = '{4'h2,  4'h6,  4'h2,  4'h6,  4'h0,  4'h1,  4'hD};

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0, 1'b0, 1'b0, 2'b00, 6'h0, 1'b0);
        clear_fwd();

        expect_at_negedge("reset", 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        rst_n = 1'b1;

        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h0000BEEF, 32'h0000CAFE, 16'h0, 1'b0, 1'b0, 2'b10, 6'h27, 1'b1);
        step();
        expect_at_negedge("rtype_nor", 32'h0000BEEF, 32'h0000CAFE, 4'hC, 1'b1, 1'b1, 1'b0, 5'd3);

        set_id(1'b1, 5'd4, 5'd2, 5'd6, 32'h00000010, 32'h00000099, 16'hFFF0, 1'b0, 1'b1, 2'b11, 6'h0, 1'b1);
        step();
        expect_at_negedge("imm_sext", 32'h00000010, 32'hFFFFFFF0, 4'h1, 1'b1, 1'b1, 1'b0, 5'd6);
        id_imm_zext = 1'b1;
        step();
        expect_at_negedge("imm_zext", 32'h00000010, 32'h0000FFF0, 4'h1, 1'b1, 1'b1, 1'b0, 5'd6);

        for (int i = 0; i < 7; i++) begin
            set_id(1'b1, 5'd1, 5'd2, 5'd7, 32'h100 + i, 32'h200 + i, 16'h0, 1'b0, 1'b0, t_cls[i], t_fn[i], 1'b1);
            step();
            expect_at_negedge($sformatf("decode%0d", i), 32'h100 + i, 32'h200 + i, t_op[i], 1'b1, 1'b1, 1'b0, 5'd7);
        end

        set_id(1'b1, 5'd1, 5'd2, 5'd8, 32'h1, 32'h2, 16'h0, 1'b0, 1'b0, 2'b10, 6'h3F, 1'b1);
        step();
        expect_at_negedge("illegal", 32'h1, 32'h2, 4'h2, 1'b1, 1'b1, 1'b1, 5'd8);
        id_funct = 6'h24;
        step();
        expect_at_negedge("illegal_clear", 32'h1, 32'h2, 4'h0, 1'b1, 1'b1, 1'b0, 5'd8);

        set_id(1'b0, 5'd1, 5'd2, 5'd9, 32'h5, 32'h6, 16'h0, 1'b0, 1'b0, 2'b00, 6'h0, 1'b1);
        step();
        expect_at_negedge("invalid_gate", 32'h5, 32'h6, 4'h2, 1'b0, 1'b0, 1'b0, 5'd9);

        set_id(1'b1, 5'd5, 5'd7, 5'd1, 32'hAAAA0000, 32'hBBBB0000, 16'h0, 1'b0, 1'b0, 2'b00, 6'h0, 1'b1);
        step();
        exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_data = 32'h11111111;
        memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_data = 32'h22222222;
        expect_at_negedge("fwd_exmem_wins", 32'h11111111, 32'hBBBB0000, 4'h2, 1'b1, 1'b1, 1'b0, 5'd1);
        exmem_reg_write = 1'b0;
        expect_at_negedge("fwd_memwb", 32'h22222222, 32'hBBBB0000, 4'h2, 1'b1, 1'b1, 1'b0, 5'd1);
        memwb_rd = 5'd7;
        expect_at_negedge("fwd_rt_memwb", 32'hAAAA0000, 32'h22222222, 4'h2, 1'b1, 1'b1, 1'b0, 5'd1);
        exmem_reg_write = 1'b1; exmem_rd = 5'd7;
        expect_at_negedge("fwd_rt_exmem", 32'hAAAA0000, 32'h11111111, 4'h2, 1'b1, 1'b1, 1'b0, 5'd1);

        set_id(1'b1, 5'd0, 5'd0, 5'd0, 32'h33, 32'h44, 16'h0, 1'b0, 1'b0, 2'b00, 6'h0, 1'b0);
        exmem_rd = 5'd0; exmem_data = 32'hDEAD0001;
        memwb_rd = 5'd0; memwb_data = 32'hDEAD0002;
        step();
        expect_at_negedge("fwd_r0_never", 32'h33, 32'h44, 4'h2, 1'b1, 1'b0, 1'b0, 5'd0);
        clear_fwd();

        set_id(1'b1, 5'd8, 5'd9, 5'd10, 32'h12345678, 32'h9ABCDEF0, 16'h0, 1'b0, 1'b0, 2'b01, 6'h0, 1'b1);
        step();
        expect_at_negedge("pre_stall", 32'h12345678, 32'h9ABCDEF0, 4'h6, 1'b1, 1'b1, 1'b0, 5'd10);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b0, 5'(i + 1), 5'(i + 2), 5'(i + 3), 32'hF0 + i, 32'hE0 + i, 16'h8000, 1'b0, 1'b1, 2'b10, 6'h3F, 1'b0);
            step();
            expect_at_negedge($sformatf("stall%0d", i), 32'h12345678, 32'h9ABCDEF0, 4'h6, 1'b1, 1'b1, 1'b0, 5'd10);
        end
        exmem_reg_write = 1'b1; exmem_rd = 5'd8; exmem_data = 32'h55555555;
        expect_at_negedge("stall_fwd", 32'h55555555, 32'h9ABCDEF0, 4'h6, 1'b1, 1'b1, 1'b0, 5'd10);
        clear_fwd();
        flush = 1'b1;
        step();
        expect_at_negedge("flush_stall", 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        flush = 1'b0; stall = 1'b0;

        set_id(1'b1, 5'd3, 5'd4, 5'd4, 32'h77, 32'h88, 16'h0, 1'b0, 1'b0, 2'b11, 6'h0, 1'b1);
        step();
        expect_at_negedge("pre_rst", 32'h77, 32'h88, 4'h1, 1'b1, 1'b1, 1'b0, 5'd4);
        stall = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        expect_now("rst_mid_stall", 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        stall = 1'b0;
        set_id(1'b1, 5'd2, 5'd3, 5'd11, 32'hCAFE0000, 32'h0000F00D, 16'h0, 1'b0, 1'b0, 2'b10, 6'h26, 1'b1);
        rst_n = 1'b1;
        step();
        expect_at_negedge("post_rst", 32'hCAFE0000, 32'h0000F00D, 4'hD, 1'b1, 1'b1, 1'b0, 5'd11);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
